daq_acq_sequencer: RTL and testbench

//  Downstream of the trigger divider. Consumes its DAQ trigger pulse and pulse counter,

---
 rtl/daq_acq_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_daq_acq_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_acq_sequencer.sv
// -----------------------------------------------------------------------------
// daq_acq_sequencer
//
// Purpose:
//   Acquisition sequencer that sits behind the trigger divider. An accepted DAQ
//   trigger starts one record. The sequencer waits a programmable delay, writes
//   a header word that carries the divider pulse counter, and then writes
//   acq_len ADC samples into the readout FIFO. trig_rdy stays low until the
//   UART side reports that the record has been drained. The divider uses
//   trig_rdy for its block/pile-up logic.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   trig          in   one-cycle DAQ trigger pulse from the divider
//   pulse_ctr     in   [5:0] divider pulse counter, latched on an accepted trig
//   acq_delay     in   [DELAY_W-1:0] trigger-to-header delay in clk cycles
//   acq_len       in   [LEN_W-1:0] number of samples per record
//   adc_data      in   [DATA_W-1:0] ADC sample stream, valid every cycle
//   fifo_full     in   readout FIFO full flag
//   readout_done  in   one-cycle pulse: the record has been fully drained
//   fifo_wr_en    out  registered FIFO write strobe
//   fifo_wr_data  out  [DATA_W+1:0] registered FIFO word
//   trig_rdy      out  registered, high only while idle
//   busy          out  ~trig_rdy
//   overflow      out  sticky, set when a word is dropped because of fifo_full
//   missed_ctr    out  [7:0] saturating count of triggers ignored while busy
//
// Word format:
//   header : {2'b11, zero pad, pulse_ctr}
//   sample : {2'b00, adc_data}
// -----------------------------------------------------------------------------
module daq_acq_sequencer #(
  parameter int DATA_W  = 14,
  parameter int LEN_W   = 8,
  parameter int DELAY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trig,
  input  logic [5:0]         pulse_ctr,
  input  logic [DELAY_W-1:0] acq_delay,
  input  logic [LEN_W-1:0]   acq_len,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               fifo_full,
  input  logic               readout_done,
  output logic               fifo_wr_en,
  output logic [DATA_W+1:0]  fifo_wr_data,
  output logic               trig_rdy,
  output logic               busy,
  output logic               overflow,
  output logic [7:0]         missed_ctr
);

  localparam int WORD_W = DATA_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    HEADER,
    CAPTURE,
    WAIT_RD
  } state_e;

  state_e             state_q,    state_d;
  logic [DELAY_W-1:0] dly_cnt_q,  dly_cnt_d;
  logic [LEN_W-1:0]   len_cnt_q,  len_cnt_d;
  logic [5:0]         pctr_q,     pctr_d;
  logic               wr_en_q,    wr_en_d;
  logic [WORD_W-1:0]  wr_data_q,  wr_data_d;
  logic               trig_rdy_q, trig_rdy_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         missed_q,   missed_d;

  // Word staged in this cycle; it appears on the FIFO port next cycle.
  logic               stage_vld;
  logic [WORD_W-1:0]  stage_word;

  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    len_cnt_d  = len_cnt_q;
    pctr_d     = pctr_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    overflow_d = overflow_q;
    missed_d   = missed_q;
    stage_vld  = 1'b0;
    stage_word = '0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          pctr_d    = pulse_ctr;
          dly_cnt_d = acq_delay;
          len_cnt_d = acq_len;
          state_d   = (acq_delay != '0) ? DELAY : HEADER;
        end
      end

      DELAY: begin
        // Counter enters holding acq_delay, so leaving at 1 gives exactly
        // acq_delay cycles here; all-ones never wraps.
        dly_cnt_d = dly_cnt_q - 1'b1;
        if (dly_cnt_q == DELAY_W'(1)) state_d = HEADER;
      end

      HEADER: begin
        stage_vld                  = 1'b1;
        stage_word[WORD_W-1 -: 2]  = 2'b11;
        stage_word[5:0]            = pctr_q;
        state_d = (len_cnt_q != '0) ? CAPTURE : WAIT_RD;
      end

      CAPTURE: begin
        stage_vld  = 1'b1;
        stage_word = {2'b00, adc_data};
        len_cnt_d  = len_cnt_q - 1'b1;
        if (len_cnt_q == LEN_W'(1)) state_d = WAIT_RD;
      end

      WAIT_RD: begin
        if (readout_done) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // fifo_full is sampled when the word is staged, one cycle ahead of the
    // strobe, so fifo_wr_en stays a clean flop output. A dropped word does not
    // stall the record.
    if (stage_vld) begin
      wr_data_d = stage_word;
      if (fifo_full) overflow_d = 1'b1;
      else           wr_en_d    = 1'b1;
    end

    // Any trigger outside IDLE is lost, including one coincident with the
    // readout_done that leaves WAIT_RD.
    if (trig && (state_q != IDLE) && (missed_q != 8'hFF))
      missed_d = missed_q + 8'd1;

    trig_rdy_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dly_cnt_q  <= '0;
      len_cnt_q  <= '0;
      pctr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      trig_rdy_q <= 1'b1;
      overflow_q <= 1'b0;
      missed_q   <= '0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      len_cnt_q  <= len_cnt_d;
      pctr_q     <= pctr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      trig_rdy_q <= trig_rdy_d;
      overflow_q <= overflow_d;
      missed_q   <= missed_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign trig_rdy     = trig_rdy_q;
  assign busy         = ~trig_rdy_q;
  assign overflow     = overflow_q;
  assign missed_ctr   = missed_q;

endmodule

// File: tb/tb_daq_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_daq_acq_sequencer
//
// Self-checking bench for daq_acq_sequencer. ADC samples and the fifo_full
// pattern are tables indexed by cycle number. When a record is triggered, the
// bench computes every FIFO write it expects (cycle and word) from the record
// timing rules and pushes them into a scoreboard queue. A monitor on the
// falling edge pops an entry whenever fifo_wr_en is high and compares both the
// cycle and the word.
// -----------------------------------------------------------------------------
module tb_daq_acq_sequencer;

  localparam int DATA_W  = 14;
  localparam int LEN_W   = 8;
  localparam int DELAY_W = 8;
  localparam int WORD_W  = DATA_W + 2;
  localparam int NCYC    = 8192;

  logic               clk          = 1'b0;
  logic               rst          = 1'b1;
  logic               trig         = 1'b0;
  logic [5:0]         pulse_ctr    = '0;
  logic [DELAY_W-1:0] acq_delay    = '0;
  logic [LEN_W-1:0]   acq_len      = '0;
  logic [DATA_W-1:0]  adc_data     = '0;
  logic               fifo_full    = 1'b0;
  logic               readout_done = 1'b0;
  logic               fifo_wr_en;
  logic [WORD_W-1:0]  fifo_wr_data;
  logic               trig_rdy;
  logic               busy;
  logic               overflow;
  logic [7:0]         missed_ctr;

  daq_acq_sequencer #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .DELAY_W(DELAY_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig        (trig),
    .pulse_ctr   (pulse_ctr),
    .acq_delay   (acq_delay),
    .acq_len     (acq_len),
    .adc_data    (adc_data),
    .fifo_full   (fifo_full),
    .readout_done(readout_done),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .trig_rdy    (trig_rdy),
    .busy        (busy),
    .overflow    (overflow),
    .missed_ctr  (missed_ctr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [WORD_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] adc_arr [NCYC];
  bit                full_arr[NCYC];
  int                model_missed = 0;
  bit                model_ovf    = 1'b0;
  int                tests        = 0;
  int                fails        = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Input tables are applied just after each rising edge.
  always @(posedge clk) begin
    #1;
    adc_data  = adc_arr[cyc];
    fifo_full = full_arr[cyc];
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got word 0x%0h at cycle %0d, expected no write",
                 fifo_wr_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
        check("wr_data", 64'(fifo_wr_data), 64'(e.data));
      end
    end
  end

  task automatic scramble_cfg();
    pulse_ctr = 6'($urandom);
    acq_delay = DELAY_W'($urandom);
    acq_len   = LEN_W'($urandom);
  endtask

  // One record. Called at the drive point of a cycle in which the DUT is idle.
  //   full_pct/full_mask : random / forced fifo_full on staging cycles
  //   trig_pct/done_pct  : random stray trig / readout_done pulses while busy
  //   cap_trigs          : trig pulses on the first cap_trigs capture cycles
  //   trig_with_done     : trig coincident with the final readout_done
  //   rst_at             : >=0 asserts rst on that capture cycle and aborts
  task automatic run_record(input int d, input int l, input logic [5:0] pc,
                            input int full_pct, input logic [31:0] full_mask,
                            input int trig_pct, input int done_pct,
                            input int cap_trigs, input bit trig_with_done,
                            input int rst_at);
    int t0, hs, r, c;
    logic [WORD_W-1:0] hdr;
    exp_t e;
    t0 = cyc;
    if (t0 + d + l + 16 >= NCYC) begin
      $display("FAIL cycle_budget: cycle %0d, required below %0d", t0, NCYC - d - l - 16);
      $fatal(1, "cycle budget exhausted");
    end
    hs = t0 + d + 1;  // header staging cycle
    for (int k = t0 + 1; k <= t0 + d + l + 2; k++)
      full_arr[k] = ($urandom_range(0, 99) < full_pct);
    for (int i = 0; i < l && i < 32; i++)
      if (full_mask[i]) full_arr[hs + 1 + i] = 1'b1;

    hdr = '0;
    hdr[WORD_W-1 -: 2] = 2'b11;
    hdr[5:0] = pc;
    if (full_arr[hs]) model_ovf = 1'b1;
    else begin e.cyc = hs + 1; e.data = hdr; exp_q.push_back(e); end
    for (int i = 0; i < l; i++) begin
      int s;
      s = hs + 1 + i;
      if (full_arr[s]) model_ovf = 1'b1;
      else begin e.cyc = s + 1; e.data = {2'b00, adc_arr[s]}; exp_q.push_back(e); end
    end
    r = t0 + d + 2 + l + $urandom_range(0, 3);

    trig      = 1'b1;
    pulse_ctr = pc;
    acq_delay = DELAY_W'(d);
    acq_len   = LEN_W'(l);
    tick();
    trig = 1'b0;
    check("trig_rdy_after_accept", 64'(trig_rdy), 64'd0);
    check("busy_after_accept", 64'(busy), 64'd1);

    while (cyc < r) begin
      c = cyc;
      if (rst_at >= 0 && c == hs + 1 + rst_at) begin
        rst = 1'b1;
        trig = 1'b0;
        readout_done = 1'b0;
        tick();
        rst = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
        model_missed = 0;
        model_ovf    = 1'b0;
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_trig_rdy", 64'(trig_rdy), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_missed", 64'(missed_ctr), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        return;
      end
      trig = ((c >= hs + 1) && (c < hs + 1 + cap_trigs)) ||
             ($urandom_range(0, 99) < trig_pct);
      readout_done = (c < t0 + d + 2 + l) && ($urandom_range(0, 99) < done_pct);
      if (trig) model_missed = sat_inc(model_missed);
      scramble_cfg();
      tick();
      trig = 1'b0;
      readout_done = 1'b0;
    end

    check("trig_rdy_wait_rd", 64'(trig_rdy), 64'd0);
    readout_done = 1'b1;
    trig = trig_with_done;
    if (trig_with_done) model_missed = sat_inc(model_missed);
    tick();
    readout_done = 1'b0;
    trig = 1'b0;
    check("trig_rdy_after_done", 64'(trig_rdy), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    check("missed_ctr", 64'(missed_ctr), 64'(model_missed));
    check("overflow", 64'(overflow), 64'(model_ovf));
    check("writes_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #(NCYC * 10);
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      adc_arr[i]  = DATA_W'($urandom);
      full_arr[i] = 1'b0;
    end

    rst = 1'b1;
    repeat (3) tick();
    check("reset_wr_en", 64'(fifo_wr_en), 64'd0);
    check("reset_wr_data", 64'(fifo_wr_data), 64'd0);
    check("reset_trig_rdy", 64'(trig_rdy), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_missed", 64'(missed_ctr), 64'd0);
    rst = 1'b0;
    tick();

    // Basic record: header 0xC005 at trigger+5, samples at +6..+9.
    run_record(3, 4, 6'd5, 0, 32'h0, 0, 0, 0, 1'b0, -1);
    // Zero delay, zero length: header only.
    run_record(0, 0, 6'd33, 0, 32'h0, 0, 0, 0, 1'b0, -1);
    // Three triggers during capture.
    run_record(2, 6, 6'd7, 0, 32'h0, 0, 0, 3, 1'b0, -1);
    // FIFO full on two sample cycles.
    run_record(1, 6, 6'd9, 0, 32'h6, 0, 0, 0, 1'b0, -1);
    // Stray readout_done pulses in DELAY/HEADER/CAPTURE.
    run_record(5, 5, 6'd12, 0, 32'h0, 0, 60, 0, 1'b0, -1);
    // Trigger coincident with the leaving readout_done is missed.
    run_record(1, 2, 6'd20, 0, 32'h0, 0, 0, 0, 1'b1, -1);
    // Reset in mid-capture, then a full record.
    run_record(2, 8, 6'd3, 0, 32'h0, 0, 0, 0, 1'b0, 3);
    run_record(2, 8, 6'd4, 0, 32'h0, 0, 0, 0, 1'b0, -1);
    // All-ones delay and length with a trigger every busy cycle.
    run_record(255, 255, 6'h3F, 0, 32'h0, 100, 0, 0, 1'b0, -1);

    repeat (30)
      run_record($urandom_range(0, 12), $urandom_range(0, 12), 6'($urandom),
                 10, 32'h0, 10, 10, 0, ($urandom_range(0, 3) == 0), -1);

    repeat (5) tick();
    check("final_writes_pending", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
